// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Commit writes values and releases tags, issue renames, flush drops renames.
module reg_file #(
    parameter int ROB_LOG = 4,
    parameter int REG_NUM = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dest,
    input  logic [ROB_LOG-1:0] issue_RobId,
    input  logic               reg_enable,
    input  logic [4:0]         reg_index,
    input  logic [ROB_LOG-1:0] reg_RobId,
    input  logic [31:0]        reg_value,
    input  logic               jump_flag,
    input  logic [4:0]         rs1_index,
    output logic [31:0]        rs1_value,
    output logic               rs1_busy,
    output logic [ROB_LOG-1:0] rs1_tag,
    input  logic [4:0]         rs2_index,
    output logic [31:0]        rs2_value,
    output logic               rs2_busy,
    output logic [ROB_LOG-1:0] rs2_tag
);

    logic [31:0]        value_q [REG_NUM];
    logic [ROB_LOG-1:0] tag_q   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic               commit_nz;
    logic               issue_nz;
    logic               commit_match;
    logic               bypass_ok;
    logic [REG_NUM-1:0] commit_sel;
    logic [REG_NUM-1:0] issue_sel;

    assign commit_nz    = reg_enable && (reg_index != 5'd0);
    assign issue_nz     = issue_valid && !jump_flag && (issue_dest != 5'd0);
    assign commit_match = busy_q[reg_index] && (tag_q[reg_index] == reg_RobId);
    assign bypass_ok    = rdy && !jump_flag && commit_nz && commit_match;

    always_comb begin
        commit_sel = '0;
        issue_sel  = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            commit_sel[i] = commit_nz && (reg_index == 5'(i));
            issue_sel[i]  = issue_nz && (issue_dest == 5'(i));
        end
    end

    // Flush beats issue, and issue beats a same-cycle tag release.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_sel[i]) begin
                    value_q[i] <= reg_value;
                end
                if (jump_flag) begin
                    busy_q[i] <= 1'b0;
                end else if (issue_sel[i]) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issue_RobId;
                end else if (commit_sel[i] && commit_match) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rs1_value = value_q[rs1_index];
        rs1_busy  = busy_q[rs1_index];
        rs1_tag   = tag_q[rs1_index];
        if (rs1_index == 5'd0) begin
            rs1_value = '0;
            rs1_busy  = 1'b0;
            rs1_tag   = '0;
        end else if (bypass_ok && (rs1_index == reg_index)) begin
            rs1_value = reg_value;
            rs1_busy  = 1'b0;
        end
    end

    always_comb begin
        rs2_value = value_q[rs2_index];
        rs2_busy  = busy_q[rs2_index];
        rs2_tag   = tag_q[rs2_index];
        if (rs2_index == 5'd0) begin
            rs2_value = '0;
            rs2_busy  = 1'b0;
            rs2_tag   = '0;
        end else if (bypass_ok && (rs2_index == reg_index)) begin
            rs2_value = reg_value;
            rs2_busy  = 1'b0;
        end
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer's commit port and beside the issue stage.
- Holds 32 committed values plus, per register, a busy bit and the ROB index of its newest in-flight producer.
- Issue renames destination registers. Commit writes values and releases tags. Decode reads operands as either a ready value or a ROB tag to wait on.
- A ROB flush (mispredict/jump) drops all outstanding renames.

Parameters:
ROB_LOG, 4, width of ROB index/tag (ROB holds 2^ROB_LOG entries)
REG_NUM, 32, number of architectural registers (index width fixed at 5)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rdy  input  1  global ready; when low, all state holds
issue_valid  input  1  an instruction with a destination register is issued this cycle
issue_dest  input  5  destination register of the issued instruction
issue_RobId  input  ROB_LOG  ROB entry allocated to the issued instruction
reg_enable  input  1  ROB commits a register write this cycle
reg_index  input  5  committed destination register
reg_RobId  input  ROB_LOG  ROB entry being committed
reg_value  input  32  committed value
jump_flag  input  1  ROB flush; all renames become invalid
rs1_index  input  5  source register 1 lookup
rs1_value  output  32  value of rs1 (valid when rs1_busy=0)
rs1_busy  output  1  rs1 awaits an in-flight producer
rs1_tag  output  ROB_LOG  ROB entry producing rs1 (valid when rs1_busy=1)
rs2_index  input  5  source register 2 lookup
rs2_value  output  32  as rs1
rs2_busy  output  1  as rs1
rs2_tag  output  ROB_LOG  as rs1

Behaviour:
- Clock/reset: one clock domain, clk. Reset rst is synchronous and active-high; rst takes priority over rdy and over every other input.
- Reset state: all 32 values = 0, busy = 0, tag = 0.
  - With no commit activity, every read output then gives value 0, busy 0, tag 0.
- rdy low (and rst low): no state change; issue, commit and flush are ignored. Read outputs remain combinational on current state.
- x0: value always 0, busy always 0, tag 0.
  - Writes and issues targeting x0 are discarded.
  - Reads of x0 return 0/0/0, including the bypass path.
- Commit, when reg_enable=1 and reg_index!=0:
  - value[reg_index] <= reg_value, unconditionally (the ROB commits in order).
  - If busy[reg_index]=1 and tag[reg_index]==reg_RobId, clear busy. Otherwise busy and tag are untouched, because a younger producer still owns the register.
- Issue, when issue_valid=1, issue_dest!=0 and jump_flag=0: busy[issue_dest] <= 1, tag[issue_dest] <= issue_RobId.
- Same-register collision: commit and issue to the same register in one cycle:
  - The value is written.
  - Issue wins busy/tag: busy=1, tag=issue_RobId, even if the committed tag matched the old tag.
- Flush, jump_flag=1:
  - A commit in the same cycle still writes its value; the ROB raises jump_flag together with reg_enable on jump commits.
  - All busy bits clear next edge, and any issue in that cycle is ignored.
  - Tags need not be cleared.
- Read ports are purely combinational, with zero latency.
  - Base result: value/busy/tag of the indexed register from current state.
  - Commit bypass applies if reg_enable=1, rdy=1, jump_flag=0, reg_index==rsX_index!=0, busy=1 and tag==reg_RobId. The output is then value=reg_value, busy=0.
  - Same-cycle issue never affects reads. The reads belong to the instruction being issued, whose sources precede its own rename.
- Flush-cycle reads: no bypass. Decode is squashed that cycle, and outputs are don't-care beyond the base result.
- Widths:
  - issue_RobId/reg_RobId are compared over the full ROB_LOG bits.
  - No arithmetic on tags; wrap-around of ROB indices needs no special handling.

Test Plan:
1. Reset then read all 32 regs -> value 0, busy 0, tag 0 for every index.
2. Issue x5 tag 3; next cycle read x5 -> busy 1, tag 3. Commit x5 tag 3 value 0xDEADBEEF while reading x5 -> same-cycle output busy 0, value 0xDEADBEEF. Next cycle, state is busy 0, value 0xDEADBEEF.
3. Issue x7 tag 2, then issue x7 tag 4. Commit x7 tag 2 value 0x11 -> value[7]=0x11, x7 stays busy with tag 4. Commit tag 4 value 0x22 -> busy 0, value 0x22.
4. In one cycle, commit x9 tag 1 (matching, value 0x55) and issue x9 tag 6 -> next cycle x9 value 0x55, busy 1, tag 6.
5. Issue x1 tag 1 and x2 tag 2. Then in one cycle: jump_flag=1 with commit x1 tag 1 value 0x80, plus issue x3 tag 3 -> next cycle x1 value 0x80 busy 0, x2 busy 0, x3 busy 0.
6. Issue x0 tag 5 and commit x0 value 0xFF -> x0 reads 0/0/0. With rdy=0, issue x4 tag 1 -> x4 stays busy 0.
